uart_tx_core: RTL and testbench
===============================

UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 20, tx_clk cycles per serial bit; legal range >= 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, FIFO entries; power of two, >= 2; used only when UART_TX_FIFO_EN is defined.
REQ-004 SHALL have port tx_clk, input, 1 bit, clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-006 SHALL have port s_data, input, DATA_BITS bits, word to transmit.
REQ-007 SHALL have port s_valid, input, 1 bit, s_data is valid.
REQ-008 SHALL have port s_ready, output, 1 bit, the block can accept a word.
REQ-009 SHALL have port parity_mode, input, 2 bits: 00 none, 01 even, 10 odd, 11 none.
REQ-010 SHALL have port stop2, input, 1 bit: 1 selects two stop bits, 0 selects one.
REQ-011 SHALL have port txd, output, 1 bit, serial line; idle high.
REQ-012 SHALL have port busy, output, 1 bit: high while a frame is in progress or a word is queued.
REQ-013 SHALL have port tx_done, output, 1 bit, one-cycle pulse when a frame ends.

Function
REQ-014 SHALL accept a word on any rising tx_clk edge where s_valid and s_ready are both high; a word SHALL NOT be accepted otherwise.
REQ-015 SHALL latch parity_mode and stop2 together with each word; changes to them mid-frame SHALL NOT affect that frame.
REQ-016 SHALL implement FSM IDLE -> START -> DATA -> PARITY (only if parity enabled) -> STOP -> IDLE or START.
REQ-017 SHALL drive txd low (START) in the cycle after the accepting edge, from IDLE; latency from accept to start bit is 1 cycle.
REQ-018 SHALL hold every bit for exactly CLKS_PER_BIT cycles; the bit counter SHALL restart at each frame start, with no phase carried over from idle.
REQ-019 SHALL send the data bits LSB first.
REQ-020 SHALL compute the parity bit as XOR of the latched data for even parity, and XNOR for odd.
REQ-021 SHALL hold txd high for 1 stop bit, or 2 when stop2 was latched high; total frame = (1+DATA_BITS+P+S)*CLKS_PER_BIT cycles, where P is the parity bit count and S the stop bit count.
REQ-022 SHALL pulse tx_done in the last cycle of the final stop bit.
REQ-023 SHALL, when a further word is available at the end of a frame, enter START in the next cycle with no idle gap.
REQ-024 SHALL, without FIFO, drive s_ready = 1 only in IDLE and in the last stop-bit cycle; this permits back-to-back frames.

Reset
REQ-025 SHALL, while rst is high, immediately set txd=1, s_ready=0, busy=0, tx_done=0, FSM=IDLE, all counters to 0 and the FIFO to empty.
REQ-026 SHALL abort a frame in progress on reset, with no glitch low on txd; the first frame after reset SHALL start cleanly.
REQ-027 SHALL drive s_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL, with UART_TX_FIFO_EN defined, place a FIFO of FIFO_DEPTH words (data, parity_mode, stop2) before the serializer, with s_ready = FIFO not full.
REQ-029 SHALL, with UART_TX_FIFO_EN defined, accept a push when full only if a pop occurs in the same cycle; otherwise the write is blocked by s_ready=0.
REQ-030 SHALL, with UART_TX_FIFO_EN defined, write and then pop in IDLE when the FIFO is empty, with the start bit 2 cycles after accept.
REQ-031 SHALL, without UART_TX_FIFO_EN, use a single holding register, with behaviour per REQ-017 and REQ-024.

Structure
REQ-032 SHALL take from shared package uart_pkg: parity_mode_t (NONE, EVEN, ODD), tx_state_t, and constant PARITY_NONE_ALT=2'b11.
REQ-033 SHALL instantiate sub-module uart_baud_gen (counter 0..CLKS_PER_BIT-1 with sync restart input and bit_tick output).

Verification
REQ-034 SHALL check: DATA_BITS=8, no parity, 1 stop, s_data=8'hA5 -> txd bits 0,1,0,1,0,0,1,0,1,1 at 20 cycles each; tx_done at cycle 200.
REQ-035 SHALL check: even parity, 8'h07 -> parity bit 1; odd parity, 8'h07 -> parity bit 0; stop2=1 -> frame of 240 cycles.
REQ-036 SHALL check: back-to-back 8'h55 then 8'hAA with s_valid held high -> second start bit immediately follows the first stop bit, no idle gap.
REQ-037 SHALL check: rst asserted at cycle 90 mid-frame -> txd=1 the same cycle; after release, 8'h3C transmits correctly.
REQ-038 SHALL check: with UART_TX_FIFO_EN and FIFO_DEPTH=4, 6 words pushed -> s_ready low after 5 accepts (4 queued + 1 in flight); all 6 words sent in order.
REQ-039 SHALL check: DATA_BITS=5, CLKS_PER_BIT=2, 5'h1F -> 7-bit frame of 14 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared UART types, constants and parity helpers.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int c_MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10
    } parity_mode_t;

    // Second encoding that also means "no parity".
    localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    typedef struct packed {
        logic [c_MAX_DATA_BITS-1:0] data;
        logic [1:0]                 parity_mode;
        logic                       stop2;
    } tx_word_t;

    function automatic logic parity_enabled(input logic [1:0] mode);
        case (mode)
            NONE, PARITY_NONE_ALT: return 1'b0;
            default:               return 1'b1;
        endcase
    endfunction

    // Unused upper data bits are zero, so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [c_MAX_DATA_BITS-1:0] data,
                                        input logic [1:0]                 mode);
        return (mode == ODD) ? ~^data : ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_baud_gen
// Brief    : Bit-period counter 0..CLKS_PER_BIT-1 with synchronous restart.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 20
)(
    input  logic tx_clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (restart || bit_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign bit_tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_tx_core
// Brief    : UART transmitter, optional parity and 1/2 stop bits.
//            Define UART_TX_FIFO_EN to put a FIFO_DEPTH-word queue in front.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_tx_core #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 20,
    parameter int FIFO_DEPTH   = 4
)(
    input  logic                 tx_clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 txd,
    output logic                 busy,
    output logic                 tx_done
);

    import uart_pkg::*;

    localparam logic [3:0] c_LAST_BIT = 4'(DATA_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > c_MAX_DATA_BITS || CLKS_PER_BIT < 2 ||
            FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
            $error("uart_tx_core: illegal parameter set");
        end
    endgenerate

    tx_state_t            r_state;
    tx_state_t            w_state_nxt;
    logic                 r_txd;
    logic                 w_txd_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic                 r_stop2;
    logic                 w_tick;
    logic                 w_last_stop;
    logic                 w_frame_end;
    logic                 w_can_load;
    logic                 w_load;
    logic                 w_word_avail;
    tx_word_t             w_in_word;
    tx_word_t             w_word;

    always_comb begin
        w_in_word                        = '0;
        w_in_word.data[DATA_BITS-1:0]    = s_data;
        w_in_word.parity_mode            = parity_mode;
        w_in_word.stop2                  = stop2;
    end

`ifdef UART_TX_FIFO_EN
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);

    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    tx_word_t         r_fifo [FIFO_DEPTH];
    logic             w_empty;
    logic             w_full;
    logic             w_push;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                          (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    // A full queue still takes a word when the head leaves in the same cycle.
    assign s_ready      = !rst && (!w_full || w_load);
    assign w_push       = s_valid && s_ready;
    assign w_word_avail = !w_empty;
    assign w_word       = r_fifo[r_rd_ptr[c_PTR_W-1:0]];
    assign busy         = (r_state != ST_IDLE) || !w_empty;

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (c_PTR_W + 1)'(1);
            if (w_load) r_rd_ptr <= r_rd_ptr + (c_PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge tx_clk) begin
        if (w_push) r_fifo[r_wr_ptr[c_PTR_W-1:0]] <= w_in_word;
    end
`else
    // The serializer registers act as the single holding register.
    assign s_ready      = !rst && w_can_load;
    assign w_word_avail = s_valid;
    assign w_word       = w_in_word;
    assign busy         = (r_state != ST_IDLE);
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .tx_clk   (tx_clk),
        .rst      (rst),
        .restart  (w_load),
        .bit_tick (w_tick)
    );

    assign w_last_stop = (r_stop_idx == r_stop2);
    assign w_frame_end = (r_state == ST_STOP) && w_tick && w_last_stop;
    assign w_can_load  = (r_state == ST_IDLE) || w_frame_end;
    assign w_load      = w_can_load && w_word_avail;
    assign tx_done     = w_frame_end;
    assign txd         = r_txd;

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // txd is registered: its next value is chosen together with the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_txd_nxt   = r_txd;
        case (r_state)
            ST_IDLE: begin
                w_txd_nxt = 1'b1;
                if (w_load) begin
                    w_state_nxt = ST_START;
                    w_txd_nxt   = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_txd_nxt   = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
                        w_txd_nxt   = r_par_en ? r_par_bit : 1'b1;
                    end else begin
                        w_txd_nxt   = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
            ST_STOP: begin
                w_txd_nxt = 1'b1;
                if (w_frame_end) begin
                    w_state_nxt = w_load ? ST_START : ST_IDLE;
                    w_txd_nxt   = !w_load;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
        end else if (w_load) begin
            r_shift    <= w_word.data[DATA_BITS-1:0];
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_par_en   <= parity_enabled(w_word.parity_mode);
            r_par_bit  <= parity_bit(w_word.data, w_word.parity_mode);
            r_stop2    <= w_word.stop2;
        end else if (w_tick) begin
            if (r_state == ST_DATA) begin
                r_bit_idx <= r_bit_idx + 4'd1;
                r_shift   <= r_shift >> 1;
            end
            if (r_state == ST_STOP) begin
                r_stop_idx <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_uart_tx_core
// Brief    : Directed self-checking bench for uart_tx_core (default and 5-bit/2-clk).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int C0 = 20;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       tx_clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [1:0] parity_mode;
    logic       stop2;
    logic       txd;
    logic       busy;
    logic       tx_done;

    logic [4:0] s_data1;
    logic       s_valid1;
    logic       s_ready1;
    logic [1:0] pm1;
    logic       st2_1;
    logic       txd1;
    logic       busy1;
    logic       tx_done1;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0]  words [0:5];
    logic [13:0] v1;
    logic [13:0] d1;
    int          g1;

    always #5 tx_clk = ~tx_clk;

    uart_tx_core u_dut (
        .tx_clk      (tx_clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .txd         (txd),
        .busy        (busy),
        .tx_done     (tx_done)
    );

    uart_tx_core #(
        .DATA_BITS    (5),
        .CLKS_PER_BIT (2)
    ) u_dut5 (
        .tx_clk      (tx_clk),
        .rst         (rst),
        .s_data      (s_data1),
        .s_valid     (s_valid1),
        .s_ready     (s_ready1),
        .parity_mode (pm1),
        .stop2       (st2_1),
        .txd         (txd1),
        .busy        (busy1),
        .tx_done     (tx_done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] d, input logic [1:0] pm, input logic s2, input bit hold);
        int g;
        g = 0;
        @(negedge tx_clk);
        s_data = d; parity_mode = pm; stop2 = s2; s_valid = 1'b1;
        while (s_ready !== 1'b1 && g < 1000) begin
            @(negedge tx_clk);
            g++;
        end
        if (g >= 1000) chk("accept timeout", {31'b0, s_ready}, 32'd1);
        @(posedge tx_clk);
        #1;
        if (!hold) begin
            s_valid = 1'b0; s_data = ~d; parity_mode = ~pm; stop2 = ~s2;
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] d, input logic [1:0] pm,
                               input logic s2, input int lat);
        logic        fb [0:11];
        int          nb, cyc, done_at;
        logic [31:0] samp, expv;
        logic        ctl_ok;
        nb = 0;
        fb[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin fb[nb] = d[i]; nb++; end
        if (pm == 2'b01)      begin fb[nb] = ^d;  nb++; end
        else if (pm == 2'b10) begin fb[nb] = ~^d; nb++; end
        fb[nb] = 1'b1; nb++;
        if (s2) begin fb[nb] = 1'b1; nb++; end
        cyc = 0; done_at = -1; ctl_ok = 1'b1;
        for (int k = 1; k < lat; k++) begin
            @(negedge tx_clk); cyc++;
            chk({tag, " lead txd"}, {31'b0, txd}, 32'd1);
            if (tx_done === 1'b1 && done_at < 0) done_at = cyc;
        end
        for (int b = 0; b < nb; b++) begin
            samp = '0;
            for (int c = 0; c < C0; c++) begin
                @(negedge tx_clk); cyc++;
                samp[c] = txd;
                if (tx_done === 1'b1 && done_at < 0) done_at = cyc;
                if (busy !== 1'b1) ctl_ok = 1'b0;
                if (tx_done !== ((b == nb - 1) && (c == C0 - 1))) ctl_ok = 1'b0;
`ifndef UART_TX_FIFO_EN
                if (s_ready !== ((b == nb - 1) && (c == C0 - 1))) ctl_ok = 1'b0;
`endif
            end
            expv = fb[b] ? 32'h000F_FFFF : 32'h0;
            chk($sformatf("%s txd bit%0d", tag, b), samp, expv);
        end
        chk({tag, " ctl"}, {31'b0, ctl_ok}, 32'd1);
        chk({tag, " done cycle"}, done_at, lat - 1 + nb * C0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
        rst = 1'b1; s_data = '0; s_valid = 1'b0; parity_mode = 2'b00; stop2 = 1'b0;
        s_data1 = '0; s_valid1 = 1'b0; pm1 = 2'b00; st2_1 = 1'b0;

        repeat (3) @(negedge tx_clk);
        chk("rst txd", {31'b0, txd}, 32'd1);
        chk("rst s_ready", {31'b0, s_ready}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst tx_done", {31'b0, tx_done}, 32'd0);
        chk("rst txd5", {31'b0, txd1}, 32'd1);
        @(posedge tx_clk); #1 rst = 1'b0;
        @(negedge tx_clk);
        chk("ready after rst", {31'b0, s_ready}, 32'd1);
        chk("ready5 after rst", {31'b0, s_ready1}, 32'd1);

        // 8N1 0xA5
        accept(8'hA5, 2'b00, 1'b0, 1'b0);
        check_frame("a5", 8'hA5, 2'b00, 1'b0, LAT);
        @(negedge tx_clk);
        chk("idle txd", {31'b0, txd}, 32'd1);
        chk("idle busy", {31'b0, busy}, 32'd0);

        // parity and two stop bits
        accept(8'h07, 2'b01, 1'b0, 1'b0);
        check_frame("even07", 8'h07, 2'b01, 1'b0, LAT);
        accept(8'h07, 2'b10, 1'b1, 1'b0);
        check_frame("odd07s2", 8'h07, 2'b10, 1'b1, LAT);

        // back-to-back with s_valid held
        accept(8'h55, 2'b00, 1'b0, 1'b1);
        s_data = 8'hAA;
`ifdef UART_TX_FIFO_EN
        fork begin @(posedge tx_clk); #1 s_valid = 1'b0; end join_none
`endif
        check_frame("b2b55", 8'h55, 2'b00, 1'b0, LAT);
`ifndef UART_TX_FIFO_EN
        fork begin @(posedge tx_clk); #1 s_valid = 1'b0; end join_none
`endif
        check_frame("b2bAA", 8'hAA, 2'b00, 1'b0, 1);

        // reset during frame cycle 90
        accept(8'h00, 2'b00, 1'b0, 1'b0);
        repeat (LAT + 89) @(negedge tx_clk);
        chk("pre-rst txd", {31'b0, txd}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid-rst txd", {31'b0, txd}, 32'd1);
        chk("mid-rst busy", {31'b0, busy}, 32'd0);
        chk("mid-rst s_ready", {31'b0, s_ready}, 32'd0);
        chk("mid-rst tx_done", {31'b0, tx_done}, 32'd0);
        repeat (2) @(posedge tx_clk);
        #1 rst = 1'b0;
        @(negedge tx_clk);
        chk("post-rst ready", {31'b0, s_ready}, 32'd1);
        chk("post-rst txd", {31'b0, txd}, 32'd1);
        accept(8'h3C, 2'b00, 1'b0, 1'b0);
        check_frame("3c", 8'h3C, 2'b00, 1'b0, LAT);

`ifdef UART_TX_FIFO_EN
        accept(words[0], 2'b00, 1'b0, 1'b1);
        fork
            begin : push_side
                int g;
                for (int i = 1; i < 6; i++) begin
                    g = 0;
                    s_data = words[i];
                    while (s_ready !== 1'b1 && g < 1000) begin
                        @(negedge tx_clk);
                        g++;
                    end
                    if (g >= 1000) chk("fifo push timeout", {31'b0, s_ready}, 32'd1);
                    @(posedge tx_clk);
                    #1;
                    if (i == 4) begin
                        @(negedge tx_clk);
                        chk("fifo full s_ready", {31'b0, s_ready}, 32'd0);
                    end
                end
                s_valid = 1'b0;
            end
            begin : line_side
                check_frame("fifo0", words[0], 2'b00, 1'b0, LAT);
                for (int j = 1; j < 6; j++)
                    check_frame($sformatf("fifo%0d", j), words[j], 2'b00, 1'b0, 1);
            end
        join
`endif

        // 5 data bits, 2 clocks per bit, 0x1F: 0 then six 1s over 14 cycles
        g1 = 0;
        @(negedge tx_clk);
        s_data1 = 5'h1F; s_valid1 = 1'b1;
        while (s_ready1 !== 1'b1 && g1 < 1000) begin
            @(negedge tx_clk);
            g1++;
        end
        @(posedge tx_clk);
        #1 s_valid1 = 1'b0;
        repeat (LAT - 1) @(negedge tx_clk);
        for (int k = 0; k < 14; k++) begin
            @(negedge tx_clk);
            v1[k] = txd1;
            d1[k] = tx_done1;
        end
        chk("d5 txd frame", {18'b0, v1}, 32'h0000_3FFC);
        chk("d5 tx_done", {18'b0, d1}, 32'h0000_2000);
        @(negedge tx_clk);
        chk("d5 idle txd", {31'b0, txd1}, 32'd1);
        chk("d5 idle busy", {31'b0, busy1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
